// File: rtl/connect4_game_ctrl_if.sv
// Button pulses in, board state out: links the debouncers, the game controller and vga_display.
interface connect4_game_ctrl_if;
    logic        BtnL;
    logic        BtnR;
    logic        BtnC;
    logic [41:0] board;
    logic [41:0] colors;
    logic [2:0]  selected_col;
    logic        player;
    logic        game_over;
    logic [1:0]  winner;

    modport master (
        output BtnL, BtnR, BtnC,
        input  board, colors, selected_col, player, game_over, winner
    );

    modport slave (
        input  BtnL, BtnR, BtnC,
        output board, colors, selected_col, player, game_over, winner
    );
endinterface

// File: rtl/connect4_game_ctrl.sv
// Connect Four game-state engine: cursor, drop, 4-direction win check, turn change.
// Define CONNECT4_SKIP_FULL_EN to make the cursor skip over full columns.
module connect4_game_ctrl (
    input  logic                 Clk,
    input  logic                 Reset,
    connect4_game_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StPlace, StCheck, StResolve} state_e;

    state_e      state_q, state_d;
    logic [41:0] board_q, board_d;
    logic [41:0] colors_q, colors_d;
    logic [2:0]  sel_q, sel_d;
    logic        player_q, player_d;
    logic        over_q, over_d;
    logic [1:0]  winner_q, winner_d;
    logic [5:0]  count_q, count_d;
    logic [2:0]  row_q, row_d;
    logic [2:0]  col_q, col_d;
    logic        pl_q, pl_d;
    logic [1:0]  dir_q, dir_d;
    logic        win_q, win_d;

    logic [2:0]  drop_row;
    logic        col_full;
    logic [5:0]  place_idx;
    logic [2:0]  line_len;
    int          step_r;
    int          step_c;

    function automatic logic own_cell(input logic [41:0] b, input logic [41:0] k,
                                      input int r, input int c, input logic p);
        logic [5:0] idx;
        idx = '0;
        if (r < 0 || r > 5 || c < 0 || c > 6) return 1'b0;
        idx = 6'(r * 7 + c);
        return b[idx] && (k[idx] == p);
    endfunction

    // Same-colour run starting one step away from (r,c), capped at 3.
    function automatic logic [1:0] run_len(input logic [41:0] b, input logic [41:0] k,
                                           input int r, input int c, input int dr,
                                           input int dc, input logic p);
        logic [1:0] n;
        logic       going;
        n     = '0;
        going = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            if (going && own_cell(b, k, r + s * dr, c + s * dc, p)) n = n + 2'd1;
            else going = 1'b0;
        end
        return n;
    endfunction

`ifdef CONNECT4_SKIP_FULL_EN
    // Nearest column with an empty top cell, stepping left or right with wrap.
    function automatic logic [2:0] next_open(input logic [41:0] b, input logic [2:0] c,
                                             input logic left);
        logic [2:0] res;
        logic [2:0] cand;
        logic       found;
        res   = c;
        cand  = c;
        found = 1'b0;
        for (int s = 0; s < 6; s++) begin
            if (left) cand = (cand == 3'd0) ? 3'd6 : cand - 3'd1;
            else      cand = (cand == 3'd6) ? 3'd0 : cand + 3'd1;
            if (!found && !b[6'd35 + 6'(cand)]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction
`endif

    // Scanning top-down leaves the lowest empty row in drop_row.
    always_comb begin
        drop_row = 3'd0;
        col_full = 1'b1;
        for (int r = 5; r >= 0; r--) begin
            if (!board_q[6'(r * 7) + 6'(sel_q)]) begin
                drop_row = 3'(r);
                col_full = 1'b0;
            end
        end
    end

    assign place_idx = 6'(row_q) * 6'd7 + 6'(col_q);

    always_comb begin
        step_r = 0;
        step_c = 1;
        case (dir_q)
            2'd0:    begin step_r = 0; step_c = 1;  end
            2'd1:    begin step_r = 1; step_c = 0;  end
            2'd2:    begin step_r = 1; step_c = 1;  end
            default: begin step_r = 1; step_c = -1; end
        endcase
        line_len = 3'd1
                 + 3'(run_len(board_q, colors_q, int'(row_q), int'(col_q), step_r, step_c, pl_q))
                 + 3'(run_len(board_q, colors_q, int'(row_q), int'(col_q), -step_r, -step_c,
                              pl_q));
    end

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        colors_d = colors_q;
        sel_d    = sel_q;
        player_d = player_q;
        over_d   = over_q;
        winner_d = winner_q;
        count_d  = count_q;
        row_d    = row_q;
        col_d    = col_q;
        pl_d     = pl_q;
        dir_d    = dir_q;
        win_d    = win_q;

        case (state_q)
            StIdle: begin
                if (!over_q) begin
                    if (bus.BtnC) begin
                        if (!col_full) begin
                            row_d   = drop_row;
                            col_d   = sel_q;
                            pl_d    = player_q;
                            state_d = StPlace;
                        end
                    end else if (bus.BtnL && !bus.BtnR) begin
`ifdef CONNECT4_SKIP_FULL_EN
                        sel_d = next_open(board_q, sel_q, 1'b1);
`else
                        sel_d = (sel_q == 3'd0) ? 3'd6 : sel_q - 3'd1;
`endif
                    end else if (bus.BtnR && !bus.BtnL) begin
`ifdef CONNECT4_SKIP_FULL_EN
                        sel_d = next_open(board_q, sel_q, 1'b0);
`else
                        sel_d = (sel_q == 3'd6) ? 3'd0 : sel_q + 3'd1;
`endif
                    end
                end
            end
            StPlace: begin
                board_d[place_idx]  = 1'b1;
                colors_d[place_idx] = pl_q;
                count_d             = count_q + 6'd1;
                dir_d               = 2'd0;
                state_d             = StCheck;
            end
            StCheck: begin
                if (line_len >= 3'd4) win_d = 1'b1;
                dir_d = dir_q + 2'd1;
                if (dir_q == 2'd3) state_d = StResolve;
            end
            StResolve: begin
                // A win on the last empty cell still counts as a win, not a draw.
                if (win_q) begin
                    over_d   = 1'b1;
                    winner_d = pl_q ? 2'b10 : 2'b01;
                end else if (count_q == 6'd42) begin
                    over_d   = 1'b1;
                    winner_d = 2'b11;
                end else begin
                    player_d = ~player_q;
`ifdef CONNECT4_SKIP_FULL_EN
                    if (board_q[6'd35 + 6'(sel_q)]) sel_d = next_open(board_q, sel_q, 1'b0);
`endif
                end
                win_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= StIdle;
            board_q  <= '0;
            colors_q <= '0;
            sel_q    <= 3'd3;
            player_q <= 1'b0;
            over_q   <= 1'b0;
            winner_q <= 2'b00;
            count_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            pl_q     <= 1'b0;
            dir_q    <= '0;
            win_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            colors_q <= colors_d;
            sel_q    <= sel_d;
            player_q <= player_d;
            over_q   <= over_d;
            winner_q <= winner_d;
            count_q  <= count_d;
            row_q    <= row_d;
            col_q    <= col_d;
            pl_q     <= pl_d;
            dir_q    <= dir_d;
            win_q    <= win_d;
        end
    end

    assign bus.board        = board_q;
    assign bus.colors       = colors_q;
    assign bus.selected_col = sel_q;
    assign bus.player       = player_q;
    assign bus.game_over    = over_q;
    assign bus.winner       = winner_q;
endmodule
